// File: rtl/nn_cfg_if.sv
// nn_cfg_if
// Configuration stream and per-layer configuration bus of the zyNet loader.
//   cfg_data/cfg_valid/cfg_ready : 32-bit word stream into the loader
//   weightValid/weightValue      : one-cycle weight strobe and word
//   biasValid/biasValue          : one-cycle bias strobe and word
//   config_layer_num/_neuron_num : target of the current strobe
// master = stream source / bus observer, slave = the loader.
interface nn_cfg_if;
   logic [31:0] cfg_data;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        weightValid;
   logic        biasValid;
   logic [31:0] weightValue;
   logic [31:0] biasValue;
   logic [31:0] config_layer_num;
   logic [31:0] config_neuron_num;

   modport master (
      output cfg_data, cfg_valid,
      input  cfg_ready, weightValid, biasValid, weightValue, biasValue,
             config_layer_num, config_neuron_num
   );

   modport slave (
      input  cfg_data, cfg_valid,
      output cfg_ready, weightValid, biasValid, weightValue, biasValue,
             config_layer_num, config_neuron_num
   );
endinterface

// File: rtl/nn_cfg_loader.sv
// nn_cfg_loader
// Sequences a flat stream of configuration words onto the 4-layer zyNet
// weight/bias bus: per layer, per neuron, NW weights then one bias.
// Ports:
//   s_axi_aclk, reset : clock, synchronous active-high reset
//   start, abort      : begin a load / cancel a load in progress
//   cfg (slave)       : word stream in, strobed configuration bus out
//   busy              : load in progress
//   cfg_done          : full load completed (level)
//   net_enable        : copy of cfg_done, gates inference upstream
//   words_loaded      : words accepted in the current load
module nn_cfg_loader #(
   parameter int L1_NN = 30, parameter int L1_NW = 784,
   parameter int L2_NN = 30, parameter int L2_NW = 30,
   parameter int L3_NN = 10, parameter int L3_NW = 30,
   parameter int L4_NN = 10, parameter int L4_NW = 10
) (
   input  logic        s_axi_aclk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   nn_cfg_if.slave     cfg,
   output logic        busy,
   output logic        cfg_done,
   output logic        net_enable,
   output logic [31:0] words_loaded
);

   typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

   state_t      state, state_nx;
   logic [2:0]  layer;
   logic [31:0] neuron;
   logic [31:0] windex;
   logic [31:0] nw_cur, nn_cur;
   logic        accept, start_ok, last_w, last_n;

   // shape of the layer currently being loaded
   always_comb begin
      nw_cur = 32'(L1_NW);
      nn_cur = 32'(L1_NN);
      case (layer)
         3'd2: begin nw_cur = 32'(L2_NW); nn_cur = 32'(L2_NN); end
         3'd3: begin nw_cur = 32'(L3_NW); nn_cur = 32'(L3_NN); end
         3'd4: begin nw_cur = 32'(L4_NW); nn_cur = 32'(L4_NN); end
         default: ;
      endcase
   end

   assign busy          = (state == LOAD_W) || (state == LOAD_B);
   // abort blocks the handshake so the word in the abort cycle is never taken
   assign cfg.cfg_ready = busy & ~abort;
   assign accept        = cfg.cfg_valid & cfg.cfg_ready;
   // start is honoured only when idle/done, and abort overrides it
   assign start_ok      = start & ~abort & ((state == IDLE) || (state == DONE));
   assign last_w        = (windex == nw_cur - 32'd1);
   assign last_n        = (neuron == nn_cur - 32'd1);
   assign cfg_done      = (state == DONE);
   assign net_enable    = cfg_done;

   always_ff @(posedge s_axi_aclk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start_ok) state_nx = LOAD_W;
         LOAD_W: begin
            if (abort)                 state_nx = IDLE;
            else if (accept && last_w) state_nx = LOAD_B;
         end
         LOAD_B: begin
            if (abort)       state_nx = IDLE;
            else if (accept) state_nx = (last_n && layer == 3'd4) ? DONE : LOAD_W;
         end
         default: state_nx = IDLE;
      endcase
   end

   // datapath: one register stage from accept to strobe
   always_ff @(posedge s_axi_aclk) begin
      if (reset) begin
         layer                 <= '0;
         neuron                <= '0;
         windex                <= '0;
         words_loaded          <= '0;
         cfg.weightValid       <= 1'b0;
         cfg.biasValid         <= 1'b0;
         cfg.weightValue       <= '0;
         cfg.biasValue         <= '0;
         cfg.config_layer_num  <= '0;
         cfg.config_neuron_num <= '0;
      end else begin
         cfg.weightValid <= 1'b0;
         cfg.biasValid   <= 1'b0;
         if (start_ok) begin
            layer        <= 3'd1;
            neuron       <= '0;
            windex       <= '0;
            words_loaded <= '0;
         end else if (accept) begin
            words_loaded          <= words_loaded + 32'd1;
            cfg.config_layer_num  <= {29'd0, layer};
            cfg.config_neuron_num <= neuron;
            if (state == LOAD_W) begin
               cfg.weightValid <= 1'b1;
               cfg.weightValue <= cfg.cfg_data;
               windex          <= windex + 32'd1;
            end else begin
               cfg.biasValid <= 1'b1;
               cfg.biasValue <= cfg.cfg_data;
               windex        <= '0;
               if (!last_n) begin
                  neuron <= neuron + 32'd1;
               end else if (layer != 3'd4) begin
                  layer  <= layer + 3'd1;
                  neuron <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_nn_cfg_loader.sv
module tb_nn_cfg_loader;

   localparam int NWORDS = 19;

   typedef struct {
      int          word;    // stream position 1..19 (data = base + word)
      logic        bias;    // expected strobe kind
      logic [31:0] layer;
      logic [31:0] neuron;
   } vec_t;

   vec_t        tbl [NWORDS];
   logic        clk, reset, start, abort;
   logic        busy, cfg_done, net_enable;
   logic [31:0] words_loaded;
   logic [31:0] base;
   int          total, bad, ptr, nstrobe;

   nn_cfg_if ifc();

   nn_cfg_loader #(
      .L1_NN(2), .L1_NW(3), .L2_NN(2), .L2_NW(2),
      .L3_NN(1), .L3_NW(2), .L4_NN(1), .L4_NW(1)
   ) dut (
      .s_axi_aclk  (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .cfg         (ifc),
      .busy        (busy),
      .cfg_done    (cfg_done),
      .net_enable  (net_enable),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // strobe scoreboard: every strobe must match the next table entry
   always @(negedge clk) begin
      if (ifc.weightValid || ifc.biasValid) begin
         if (ptr >= NWORDS) begin
            chk("extra_strobe", 32'd1, 32'd0);
         end else begin
            chk("strobe_kind", {30'd0, ifc.biasValid, ifc.weightValid},
                tbl[ptr].bias ? 32'd2 : 32'd1);
            chk("strobe_value", ifc.biasValid ? ifc.biasValue : ifc.weightValue,
                base + 32'(tbl[ptr].word));
            chk("strobe_layer", ifc.config_layer_num, tbl[ptr].layer);
            chk("strobe_neuron", ifc.config_neuron_num, tbl[ptr].neuron);
         end
         ptr++;
         nstrobe++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"},  {31'd0, ifc.cfg_ready},   32'd0);
      chk({tag, "_wv"},     {31'd0, ifc.weightValid}, 32'd0);
      chk({tag, "_bv"},     {31'd0, ifc.biasValid},   32'd0);
      chk({tag, "_wval"},   ifc.weightValue,          32'd0);
      chk({tag, "_bval"},   ifc.biasValue,            32'd0);
      chk({tag, "_layer"},  ifc.config_layer_num,     32'd0);
      chk({tag, "_neuron"}, ifc.config_neuron_num,    32'd0);
      chk({tag, "_busy"},   {31'd0, busy},            32'd0);
      chk({tag, "_done"},   {31'd0, cfg_done},        32'd0);
      chk({tag, "_nen"},    {31'd0, net_enable},      32'd0);
      chk({tag, "_words"},  words_loaded,             32'd0);
   endtask

   task automatic do_start(input logic [31:0] b);
      start = 1'b1;
      tick();
      start = 1'b0;
      base = b; ptr = 0; nstrobe = 0;
      chk("start_ready", {31'd0, ifc.cfg_ready}, 32'd1);
      chk("start_busy",  {31'd0, busy},          32'd1);
      chk("start_done",  {31'd0, cfg_done},      32'd0);
      chk("start_nen",   {31'd0, net_enable},    32'd0);
      chk("start_words", words_loaded,           32'd0);
   endtask

   // present words from..to; bp inserts random idle cycles; start pulsed at start_at
   task automatic send(input int from, input int to, input bit bp, input int start_at);
      for (int k = from; k <= to; k++) begin
         if (bp) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin ifc.cfg_valid = 1'b0; tick(); end
         end
         ifc.cfg_valid = 1'b1;
         ifc.cfg_data  = base + 32'(k);
         start         = (k == start_at);
         tick();
      end
      ifc.cfg_valid = 1'b0;
      start         = 1'b0;
   endtask

   task automatic chk_end(input string tag);
      chk({tag, "_bv"},     {31'd0, ifc.biasValid}, 32'd1);
      chk({tag, "_layer"},  ifc.config_layer_num,   32'd4);
      chk({tag, "_neuron"}, ifc.config_neuron_num,  32'd0);
      chk({tag, "_done"},   {31'd0, cfg_done},      32'd1);
      chk({tag, "_nen"},    {31'd0, net_enable},    32'd1);
      chk({tag, "_words"},  words_loaded,           32'd19);
      chk({tag, "_busy"},   {31'd0, busy},          32'd0);
      chk({tag, "_ready"},  {31'd0, ifc.cfg_ready}, 32'd0);
      tick();
      chk({tag, "_bv_1cyc"}, {31'd0, ifc.biasValid}, 32'd0);
      chk({tag, "_bhold"},   ifc.biasValue,          base + 32'd19);
      chk({tag, "_count"},   32'(nstrobe),           32'd19);
   endtask

   initial begin
      tbl[0]  = '{1,  0, 1, 0}; tbl[1]  = '{2,  0, 1, 0}; tbl[2]  = '{3,  0, 1, 0};
      tbl[3]  = '{4,  1, 1, 0};
      tbl[4]  = '{5,  0, 1, 1}; tbl[5]  = '{6,  0, 1, 1}; tbl[6]  = '{7,  0, 1, 1};
      tbl[7]  = '{8,  1, 1, 1};
      tbl[8]  = '{9,  0, 2, 0}; tbl[9]  = '{10, 0, 2, 0}; tbl[10] = '{11, 1, 2, 0};
      tbl[11] = '{12, 0, 2, 1}; tbl[12] = '{13, 0, 2, 1}; tbl[13] = '{14, 1, 2, 1};
      tbl[14] = '{15, 0, 3, 0}; tbl[15] = '{16, 0, 3, 0}; tbl[16] = '{17, 1, 3, 0};
      tbl[17] = '{18, 0, 4, 0}; tbl[18] = '{19, 1, 4, 0};

      total = 0; bad = 0; ptr = 0; nstrobe = 0; base = '0;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      ifc.cfg_valid = 1'b0; ifc.cfg_data = '0;
      tick(); tick();
      chk_zero("reset");
      reset = 1'b0;
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // full load, back-to-back
      do_start(32'h1000_0000);
      send(1, NWORDS, 1'b0, 0);
      chk_end("full");

      // reload from DONE, then the same stream under backpressure
      do_start(32'h2000_0000);
      send(1, NWORDS, 1'b1, 0);
      chk_end("bp");

      // abort while presenting word 7
      do_start(32'h3000_0000);
      send(1, 6, 1'b0, 0);
      ifc.cfg_valid = 1'b1;
      ifc.cfg_data  = base + 32'd7;
      abort         = 1'b1;
      #1;
      chk("abort_ready", {31'd0, ifc.cfg_ready}, 32'd0);
      tick();
      abort = 1'b0;
      chk("abort_wv",    {31'd0, ifc.weightValid}, 32'd0);
      chk("abort_busy",  {31'd0, busy},            32'd0);
      chk("abort_done",  {31'd0, cfg_done},        32'd0);
      chk("abort_words", words_loaded,             32'd6);
      chk("abort_ready2",{31'd0, ifc.cfg_ready},   32'd0);
      tick(); tick();
      ifc.cfg_valid = 1'b0;
      chk("abort_count", 32'(nstrobe), 32'd6);

      // abort and start together in IDLE: abort wins
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("absta_busy", {31'd0, busy}, 32'd0);

      // start pulsed with word 10 is ignored
      do_start(32'h4000_0000);
      send(1, NWORDS, 1'b0, 10);
      chk_end("ignstart");

      // abort in DONE has no effect
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("done_abort", {31'd0, cfg_done}, 32'd1);

      // reset while presenting word 12
      do_start(32'h5000_0000);
      send(1, 11, 1'b0, 0);
      ifc.cfg_valid = 1'b1;
      ifc.cfg_data  = base + 32'd12;
      reset         = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("midrst");
      repeat (4) tick();
      ifc.cfg_valid = 1'b0;
      chk("midrst_count", 32'(nstrobe), 32'd11);
      chk("midrst_busy",  {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nn_cfg_loader.md
# nn_cfg_loader

Weight/bias configuration sequencer for the 4-layer zyNet datapath. Accepts a flat stream of 32-bit configuration words over a valid/ready interface and drives the shared per-layer configuration bus: `weightValid`, `biasValid`, `weightValue`, `biasValue`, `config_layer_num` and `config_neuron_num`. Words are dispatched layer by layer and neuron by neuron. The block holds inference disabled (`net_enable` low) until a full load completes.

## Interface

Parameters:
- `L1_NN`, 30: neurons in layer 1; `L1_NW`, 784: weights per neuron in layer 1
- `L2_NN`, 30; `L2_NW`, 30
- `L3_NN`, 10; `L3_NW`, 30
- `L4_NN`, 10; `L4_NW`, 10
- All NN/NW values are ≥1.

Ports:
- `s_axi_aclk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle pulse; begins a load
- `abort`  in  1  cancels a load in progress
- `cfg_data`  in  32  configuration word
- `cfg_valid`  in  1  `cfg_data` valid
- `cfg_ready`  out  1  loader accepts a word this cycle
- `weightValid`  out  1  one-cycle strobe: `weightValue` is valid
- `biasValid`  out  1  one-cycle strobe: `biasValue` is valid
- `weightValue`  out  32  weight word
- `biasValue`  out  32  bias word
- `config_layer_num`  out  32  target layer (1..4)
- `config_neuron_num`  out  32  target neuron (0..NN-1)
- `busy`  out  1  load in progress
- `cfg_done`  out  1  level; a full load has completed
- `net_enable`  out  1  level; equals `cfg_done`; gates `axis_in_data_ready` upstream
- `words_loaded`  out  32  count of words accepted in the current load

## Operation

- State machine states: IDLE, LOAD_W, LOAD_B, DONE.
- **IDLE**
  - On `start`: clear all counters and `words_loaded`, set layer=1, neuron=0, windex=0, then go to LOAD_W.
  - Otherwise remain in IDLE.
- **LOAD_W**
  - `cfg_ready`=1.
  - Each accepted word (`cfg_valid`&`cfg_ready`) is a weight:
    - Register it to `weightValue` and strobe `weightValid`.
    - Increment `windex`.
  - When `windex` reaches NW(layer)-1 on an accept, go to LOAD_B.
- **LOAD_B**
  - `cfg_ready`=1.
  - An accepted word is the bias:
    - Register it to `biasValue` and strobe `biasValid`.
    - Clear `windex`.
  - Then one of three transitions:
    - Neuron < NN(layer)-1: increment neuron, go to LOAD_W.
    - Last neuron and layer < 4: layer+1, neuron=0, go to LOAD_W.
    - Last neuron of layer 4: go to DONE.
- **DONE**
  - `cfg_done`=`net_enable`=1, `busy`=0, `cfg_ready`=0.
  - On `start`: drop `cfg_done` and reload (go to LOAD_W with counters cleared).
- **Ordering and counters**
  - Stream order is fixed: for each layer 1..4, for each neuron 0..NN-1, NW weights followed by 1 bias.
  - Total words per load = Σ NN·(NW+1).
  - `words_loaded` increments on every accept. It wraps modulo 2^32 (unreachable in practice).
- **Control inputs**
  - `busy`=1 in LOAD_W/LOAD_B.
  - `start` while busy: ignored.
  - `abort` while busy: go to IDLE the next cycle. `cfg_done`=0, no strobe issued for a word presented in the abort cycle. The word is not accepted (`cfg_ready` forced to 0 in that cycle).
  - `abort` in IDLE/DONE: no effect.
  - `abort` and `start` in the same cycle: `abort` wins.
- `cfg_valid` low stalls the sequence indefinitely. No timeout.
- `weightValue`/`biasValue` hold their last value between strobes. `config_layer_num`/`config_neuron_num` are updated together with the strobe.

## Timing

- **Reset:** state IDLE, all outputs 0 (`cfg_ready`, strobes, values, layer/neuron nums, `busy`, `cfg_done`, `net_enable`, `words_loaded`).
- **Latency:** word accepted at edge t, strobe plus data plus layer/neuron num valid during cycle t+1 (one register stage). Strobes are exactly one cycle per word.
- **Throughput:** one word per cycle with no bubbles, including across the LOAD_W→LOAD_B→LOAD_W and layer boundaries.
- **`start` in IDLE:** `cfg_ready` rises the following cycle.
- **End of load:** final bias accepted at edge t, `biasValid` high in cycle t+1, `cfg_done`/`net_enable` high from cycle t+1.
- **Reset mid-load:** next cycle is the reset state. No further strobes; partial layer contents are left as-is.
- `cfg_ready` is combinational from state and `abort` only. It has no dependency on `cfg_valid`.

## Test plan

Test configuration: L1 2/3, L2 2/2, L3 1/2, L4 1/1 (NN/NW), giving 19 words.

1. **Full load:** `start`, then stream words 1..19 back-to-back. Expect:
   - `weightValid` on words 1,2,3 at layer 1 neuron 0; `biasValid` on word 4.
   - Words 5–8 go to layer 1 neuron 1.
   - Word 19 arrives as `biasValid` at layer 4 neuron 0.
   - `cfg_done`=`net_enable`=1 the same cycle; `words_loaded`=19.
2. **Backpressure:** the same stream with `cfg_valid` toggled randomly. Expect an identical strobe/value/layer/neuron sequence, with exactly 19 strobes total.
3. **Abort:** assert `abort` when presenting word 7. Expect:
   - `cfg_ready`=0 in that cycle; no strobe for word 7.
   - IDLE next cycle; `cfg_done`=0; `words_loaded` frozen at 6.
4. **Ignored start:** `start` pulsed during word 10. Expect no effect; the load completes normally at word 19.
5. **Reload:** `start` in DONE. Expect:
   - `net_enable` drops the next cycle.
   - The new stream begins at layer 1 neuron 0; `words_loaded` restarts at 0.
6. **Reset mid-load:** assert `reset` at word 12. Expect all outputs 0 the next cycle, `cfg_ready`=0, and no strobes until a new `start`.
